// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the multi-port register file.
// EBR geometry is fixed by the target FPGA's block RAM primitive.
package regfile_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;
  localparam int EBR_WIDTH     = 16;
  localparam int EBR_DEPTH     = 256;

  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_RUN   = 1'b1;

  typedef enum logic {
    S_CLEAR = ST_CLEAR,
    S_RUN   = ST_RUN
  } state_e;

endpackage

// File: rtl/regfile_bank.sv
// One read bank: simple dual-port, synchronous-read RAM built from 16-bit x 256 EBR slices.
// The read returns the pre-write contents on an address collision; the top handles forwarding.
module regfile_bank
  import regfile_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEFAULT,
  parameter  int NREGS = NREGS_DEFAULT,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   wrAddr,
  input  logic [XLEN-1:0] wrData,
  input  logic            re,
  input  logic [AW-1:0]   rdAddr,
  output logic [XLEN-1:0] rdData
);

  localparam int SLICES = XLEN / EBR_WIDTH;
  localparam int EBR_AW = $clog2(EBR_DEPTH);

  logic [EBR_AW-1:0] wrAddrExt;
  logic [EBR_AW-1:0] rdAddrExt;

  assign wrAddrExt = EBR_AW'(wrAddr);
  assign rdAddrExt = EBR_AW'(rdAddr);

  for (genvar s = 0; s < SLICES; s++) begin : gSlice
    logic [EBR_WIDTH-1:0] mem [EBR_DEPTH];
    logic [EBR_WIDTH-1:0] q;

    // NOTE: the array has no reset branch so it maps onto block RAM; clearing is sequenced by the top.
    always_ff @(posedge clk) begin
      if (we) mem[wrAddrExt] <= wrData[s*EBR_WIDTH +: EBR_WIDTH];
      if (re) q <= mem[rdAddrExt];
    end

    assign rdData[s*EBR_WIDTH +: EBR_WIDTH] = q;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: one write port, NREAD registered read ports, write-first
// forwarding, optional hardwired x0 and a sequenced post-reset clear of the EBR banks.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN           = XLEN_DEFAULT,
  parameter  int NREGS          = NREGS_DEFAULT,
  parameter  int NREAD          = 2,
  parameter  bit ZERO_REG       = 1'b1,
  parameter  bit CLEAR_ON_RESET = 1'b1,
  localparam int AW             = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  ready,
  input  logic                  write,
  input  logic [AW-1:0]         wrAddr,
  input  logic [XLEN-1:0]       wrData,
  input  logic [NREAD-1:0]      rdEn,
  input  logic [NREAD*AW-1:0]   rdAddr,
  output logic [NREAD*XLEN-1:0] rdData
);

  localparam bit          FULL_RANGE  = (NREGS == (1 << AW));
  localparam logic [AW-1:0] LAST_PTR  = AW'(NREGS - 1);
  localparam state_e      RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_RUN;

  state_e        state, stateNext;
  logic [AW-1:0] clrPtr, clrPtrNext;
  logic          clearing;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= RESET_STATE;
      clrPtr <= '0;
      ready  <= 1'b0;
    end else begin
      state  <= stateNext;
      clrPtr <= clrPtrNext;
      ready  <= (stateNext == S_RUN);
    end
  end

  // NOTE: every output of this block is assigned a default first, so no latch can be inferred.
  always_comb begin
    stateNext  = state;
    clrPtrNext = clrPtr;
    clearing   = 1'b0;
    case (state)
      S_CLEAR: begin
        clearing   = 1'b1;
        clrPtrNext = clrPtr + 1'b1;
        if (clrPtr == LAST_PTR) begin
          stateNext  = S_RUN;
          clrPtrNext = '0;
        end
      end
      default: ;
    endcase
  end

  logic wrInRange;
  if (FULL_RANGE) begin : gWrFull
    assign wrInRange = 1'b1;
  end else begin : gWrPart
    assign wrInRange = (wrAddr < AW'(NREGS));
  end

  logic weRun;
  assign weRun = write & ready & wrInRange & ~(ZERO_REG && (wrAddr == '0));

  // The clear shares the single write port of every bank.
  logic            bankWe;
  logic [AW-1:0]   bankWrAddr;
  logic [XLEN-1:0] bankWrData;
  assign bankWe     = clearing | weRun;
  assign bankWrAddr = clearing ? clrPtr : wrAddr;
  assign bankWrData = clearing ? '0 : wrData;

  for (genvar i = 0; i < NREAD; i++) begin : gPort
    logic [AW-1:0]   addr;
    logic            en;
    logic            inRange;
    logic            zeroSel;
    logic            fwdSel;
    logic [XLEN-1:0] fwdData;
    logic [XLEN-1:0] bankQ;

    assign addr = rdAddr[i*AW +: AW];
    assign en   = ready & rdEn[i];

    if (FULL_RANGE) begin : gRdFull
      assign inRange = 1'b1;
    end else begin : gRdPart
      assign inRange = (addr < AW'(NREGS));
    end

    regfile_bank #(
      .XLEN  (XLEN),
      .NREGS (NREGS)
    ) uBank (
      .clk    (clk),
      .we     (bankWe),
      .wrAddr (bankWrAddr),
      .wrData (bankWrData),
      .re     (en),
      .rdAddr (addr),
      .rdData (bankQ)
    );

    // Selection is captured alongside the bank read, so rdData is driven only by registers.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        zeroSel <= 1'b1;
        fwdSel  <= 1'b0;
        fwdData <= '0;
      end else if (en) begin
        zeroSel <= ~inRange | (ZERO_REG && (addr == '0));
        fwdSel  <= weRun & (wrAddr == addr);
        fwdData <= wrData;
      end
    end

    assign rdData[i*XLEN +: XLEN] = zeroSel ? '0 : (fwdSel ? fwdData : bankQ);
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: default, NREGS=24, and a 64-bit/4-port no-clear variant.
// Stimulus pushes expected read data with its due cycle; a negedge monitor compares.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // DUT A: defaults
  logic        aReset, aReady, aWrite;
  logic [4:0]  aWrAddr;
  logic [31:0] aWrData;
  logic [1:0]  aRdEn;
  logic [9:0]  aRdAddr;
  logic [63:0] aRdData;

  // DUT B: NREGS=24
  logic        bReset, bReady, bWrite;
  logic [4:0]  bWrAddr;
  logic [31:0] bWrData;
  logic [1:0]  bRdEn;
  logic [9:0]  bRdAddr;
  logic [63:0] bRdData;

  // DUT C: XLEN=64, NREGS=8, NREAD=4, no clear
  logic         cReset, cReady, cWrite;
  logic [2:0]   cWrAddr;
  logic [63:0]  cWrData;
  logic [3:0]   cRdEn;
  logic [11:0]  cRdAddr;
  logic [255:0] cRdData;

  regfile_mp uA (
    .clk(clk), .reset(aReset), .ready(aReady), .write(aWrite), .wrAddr(aWrAddr),
    .wrData(aWrData), .rdEn(aRdEn), .rdAddr(aRdAddr), .rdData(aRdData)
  );

  regfile_mp #(.NREGS(24)) uB (
    .clk(clk), .reset(bReset), .ready(bReady), .write(bWrite), .wrAddr(bWrAddr),
    .wrData(bWrData), .rdEn(bRdEn), .rdAddr(bRdAddr), .rdData(bRdData)
  );

  regfile_mp #(.XLEN(64), .NREGS(8), .NREAD(4), .CLEAR_ON_RESET(1'b0)) uC (
    .clk(clk), .reset(cReset), .ready(cReady), .write(cWrite), .wrAddr(cWrAddr),
    .wrData(cWrData), .rdEn(cRdEn), .rdAddr(cRdAddr), .rdData(cRdData)
  );

  typedef struct {
    int          due;
    int          dut;
    int          port;
    logic [63:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t monE;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] getRd(input int d, input int p);
    case (d)
      0:       return 64'(aRdData[p*32 +: 32]);
      1:       return 64'(bRdData[p*32 +: 32]);
      default: return cRdData[p*64 +: 64];
    endcase
  endfunction

  function automatic logic rdyOf(input int d);
    case (d)
      0:       return aReady;
      1:       return bReady;
      default: return cReady;
    endcase
  endfunction

  // Expected data for a read issued now appears after the next rising edge.
  task automatic expectRd(input int d, input int p, input logic [63:0] v, input string name);
    sb.push_back('{cyc + 1, d, p, v, name});
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      monE = sb.pop_front();
      check(monE.name, getRd(monE.dut, monE.port), monE.exp);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic aSet(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [1:0] en, input logic [4:0] r0, input logic [4:0] r1);
    aWrite = w; aWrAddr = wa; aWrData = wd; aRdEn = en; aRdAddr = {r1, r0};
  endtask

  task automatic bSet(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [1:0] en, input logic [4:0] r0, input logic [4:0] r1);
    bWrite = w; bWrAddr = wa; bWrData = wd; bRdEn = en; bRdAddr = {r1, r0};
  endtask

  task automatic cSet(input logic w, input logic [2:0] wa, input logic [63:0] wd,
                      input logic [3:0] en, input logic [11:0] ra);
    cWrite = w; cWrAddr = wa; cWrData = wd; cRdEn = en; cRdAddr = ra;
  endtask

  task automatic waitReady(input int d, output int n);
    n = 0;
    while (!rdyOf(d) && n < 300) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    aReset = 1'b1; bReset = 1'b1; cReset = 1'b1;
    aSet(0, 0, 0, 0, 0, 0);
    bSet(0, 0, 0, 0, 0, 0);
    cSet(0, 0, 0, 0, 0);
    tick();
    tick();
    check("a_reset_ready", 64'(aReady), 64'd0);
    check("a_reset_rddata", aRdData, 64'd0);

    // Test 1: ready is seen low by edges 1..32 and high by edge 33.
    aReset = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      check($sformatf("t1_ready_edge%0d", k), 64'(aReady), 64'(k >= 33));
      if (k < 33) tick();
    end
    aSet(0, 0, 0, 2'b01, 5'd5, 5'd0);
    expectRd(0, 0, 64'h0, "t1_read_x5");
    tick();
    aSet(0, 0, 0, 0, 0, 0);
    tick();

    // Test 3: same-edge forwarding to both ports, then to port 0 only.
    aSet(1, 5'd7, 32'h12345678, 2'b11, 5'd7, 5'd7);
    expectRd(0, 0, 64'h12345678, "t3_fwd_p0");
    expectRd(0, 1, 64'h12345678, "t3_fwd_p1");
    tick();
    aSet(1, 5'd7, 32'hCAFEF00D, 2'b01, 5'd7, 5'd0);
    expectRd(0, 0, 64'hCAFEF00D, "t3_fwd2_p0");
    expectRd(0, 1, 64'h12345678, "t3_hold_p1");
    tick();

    // Test 4: port-1 hold across an overwrite.
    aSet(1, 5'd3, 32'hA5A5A5A5, 2'b00, 5'd0, 5'd0);
    tick();
    aSet(0, 0, 0, 2'b10, 5'd0, 5'd3);
    expectRd(0, 1, 64'hA5A5A5A5, "t4_read_x3");
    tick();
    aSet(1, 5'd3, 32'h5A5A5A5A, 2'b00, 5'd0, 5'd3);
    expectRd(0, 1, 64'hA5A5A5A5, "t4_hold_during_write");
    tick();
    aSet(0, 0, 0, 2'b00, 5'd0, 5'd3);
    expectRd(0, 1, 64'hA5A5A5A5, "t4_hold_idle");
    tick();
    aSet(0, 0, 0, 2'b10, 5'd0, 5'd3);
    expectRd(0, 1, 64'h5A5A5A5A, "t4_reread_x3");
    tick();

    // Test 5: fill, reset, reset again mid-clear with a write pending.
    for (int i = 1; i < 32; i++) begin
      aSet(1, 5'(i), 32'(i), 2'b00, 5'd0, 5'd0);
      tick();
    end
    aSet(0, 0, 0, 2'b11, 5'd31, 5'd1);
    expectRd(0, 0, 64'd31, "t5_fill_x31");
    expectRd(0, 1, 64'd1, "t5_fill_x1");
    tick();
    aSet(0, 0, 0, 0, 0, 0);
    tick();
    aReset = 1'b1;
    #1;
    check("t5_rst_rddata", aRdData, 64'd0);
    check("t5_rst_ready", 64'(aReady), 64'd0);
    tick();
    aReset = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      if (k >= 4) begin
        aSet(1, 5'd4, 32'h44, 2'b11, 5'd31, 5'd4);
        expectRd(0, 0, 64'h0, "t5_clear_rd_ignored_p0");
        expectRd(0, 1, 64'h0, "t5_clear_rd_ignored_p1");
      end
      tick();
    end
    aReset = 1'b1;
    #1;
    check("t5_midclear_ready", 64'(aReady), 64'd0);
    tick();
    aReset = 1'b0;
    aSet(0, 0, 0, 0, 0, 0);
    waitReady(0, n);
    check("t5_restart_clear_len", 64'(n), 64'd32);
    for (int i = 0; i < 16; i++) begin
      aSet(0, 0, 0, 2'b11, 5'(i), 5'(i + 16));
      expectRd(0, 0, 64'h0, $sformatf("t5_cleared_x%0d", i));
      expectRd(0, 1, 64'h0, $sformatf("t5_cleared_x%0d", i + 16));
      tick();
    end
    aSet(0, 0, 0, 0, 0, 0);
    tick();

    // Test 2: zero register and out-of-range addresses with NREGS=24.
    bReset = 1'b0;
    waitReady(1, n);
    check("t2_clear_len", 64'(n), 64'd24);
    bSet(1, 5'd0, 32'hDEADBEEF, 2'b11, 5'd0, 5'd0);
    expectRd(1, 0, 64'h0, "t2_x0_same_edge_p0");
    expectRd(1, 1, 64'h0, "t2_x0_same_edge_p1");
    tick();
    bSet(0, 0, 0, 2'b11, 5'd0, 5'd0);
    expectRd(1, 0, 64'h0, "t2_x0_p0");
    expectRd(1, 1, 64'h0, "t2_x0_p1");
    tick();
    bSet(1, 5'd30, 32'h11111111, 2'b01, 5'd30, 5'd0);
    expectRd(1, 0, 64'h0, "t2_a30_same_edge");
    tick();
    bSet(1, 5'd23, 32'h23232323, 2'b11, 5'd30, 5'd31);
    expectRd(1, 0, 64'h0, "t2_a30_read");
    expectRd(1, 1, 64'h0, "t2_a31_read");
    tick();
    bSet(0, 0, 0, 2'b11, 5'd23, 5'd30);
    expectRd(1, 0, 64'h23232323, "t2_x23_last_entry");
    expectRd(1, 1, 64'h0, "t2_a30_reread");
    tick();
    bSet(0, 0, 0, 0, 0, 0);
    tick();

    // Test 6: 64-bit, 4 ports, no clear.
    cReset = 1'b0;
    check("t6_ready_at_release", 64'(cReady), 64'd0);
    tick();
    check("t6_ready_edge1", 64'(cReady), 64'd1);
    cSet(1, 3'd2, 64'h0123456789ABCDEF, 4'h0, 12'h0);
    tick();
    cSet(0, 0, 0, 4'hF, {3'd2, 3'd2, 3'd2, 3'd2});
    for (int p = 0; p < 4; p++) expectRd(2, p, 64'h0123456789ABCDEF, $sformatf("t6_x2_p%0d", p));
    tick();
    cSet(1, 3'd5, 64'hFEDCBA9876543210, 4'hF, {3'd5, 3'd5, 3'd5, 3'd5});
    for (int p = 0; p < 4; p++) expectRd(2, p, 64'hFEDCBA9876543210, $sformatf("t6_fwd_p%0d", p));
    tick();
    cSet(0, 0, 0, 4'hF, {3'd5, 3'd5, 3'd2, 3'd0});
    expectRd(2, 0, 64'h0, "t6_x0");
    expectRd(2, 1, 64'h0123456789ABCDEF, "t6_mix_x2");
    expectRd(2, 2, 64'hFEDCBA9876543210, "t6_mix_x5_p2");
    expectRd(2, 3, 64'hFEDCBA9876543210, "t6_mix_x5_p3");
    tick();
    cSet(0, 0, 0, 0, 0);

    n = 0;
    while (sb.size() > 0 && n < 10) begin
      tick();
      n++;
    end
    check("sb_drain", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
